// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped instruction cache with one 32-bit word per line, sitting
//   between the IF stage and mem_ctrl. Hits are answered combinationally in
//   the request cycle; misses hold a fetch request to mem_ctrl until the word
//   arrives, fill the line and forward the word to IF when IF is still asking
//   for the same PC. A flush (jmp_wrong_i) aborts an outstanding miss.
//
//   Optional feature macro: ICACHE_STATS_EN
//     defined   -> hit_cnt_o / miss_cnt_o are live 32-bit wrapping counters
//     undefined -> both ports are tied to zero and no counter flops exist
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active low
//   jmp_wrong_i     flush: abort outstanding miss, drop current fetch
//   if_require_i    IF requests an instruction this cycle
//   if_addr_i       fetch PC (bits [1:0] ignored)
//   if_inst_o       instruction word to IF
//   if_valid_o      if_inst_o is valid for if_addr_i this cycle
//   inst_require_o  fetch request to mem_ctrl
//   inst_addr_o     word-aligned fetch address to mem_ctrl
//   inst_data_i     word returned by mem_ctrl
//   inst_enable_i   one-cycle pulse, inst_data_i valid
//   inst_busy_i     mem_ctrl busy (informational, not used)
//   hit_cnt_o       hit counter
//   miss_cnt_o      miss counter
// -----------------------------------------------------------------------------
module icache_direct #(
    parameter int INDEX_BITS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_wrong_i,
    input  logic        if_require_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        inst_require_o,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_data_i,
    input  logic        inst_enable_i,
    input  logic        inst_busy_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [29:0]           miss_addr_q, miss_addr_d;   // word address of the miss
    logic [LINES-1:0]      valid_q;

    // Storage arrays are not reset; the valid bits alone qualify their contents.
    logic [31:0]           data_mem [LINES];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_en;
    logic                  hit_evt;
    logic                  miss_evt;
    logic                  unused_sig;

    assign req_idx  = if_addr_i[INDEX_BITS+1:2];
    assign req_tag  = if_addr_i[31:INDEX_BITS+2];
    assign fill_idx = miss_addr_q[INDEX_BITS-1:0];
    assign fill_tag = miss_addr_q[29:INDEX_BITS];

    // Lookup reads the arrays asynchronously so a hit is answered in the same
    // cycle; a fill written this cycle only becomes visible on the next one.
    assign hit = if_require_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

    assign inst_addr_o = {miss_addr_q, 2'b00};

    always_comb begin
        state_d        = state_q;
        miss_addr_d    = miss_addr_q;
        if_valid_o     = 1'b0;
        if_inst_o      = 32'h0;
        inst_require_o = 1'b0;
        fill_en        = 1'b0;
        hit_evt        = 1'b0;
        miss_evt       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!jmp_wrong_i) begin
                    if (hit) begin
                        if_valid_o = 1'b1;
                        if_inst_o  = data_mem[req_idx];
                        hit_evt    = 1'b1;
                    end else if (if_require_i) begin
                        miss_addr_d = if_addr_i[31:2];
                        state_d     = S_MISS;
                        miss_evt    = 1'b1;
                    end
                end
            end
            S_MISS: begin
                if (jmp_wrong_i) begin
                    // Abort: no fill, even if the response lands this cycle.
                    state_d = S_IDLE;
                end else begin
                    // Drop the request in the response cycle so mem_ctrl does
                    // not launch a second fetch.
                    inst_require_o = !inst_enable_i;
                    if (inst_enable_i) begin
                        fill_en = 1'b1;
                        state_d = S_IDLE;
                        // Forward only if IF is still asking for the missed PC.
                        if (if_require_i && (if_addr_i[31:2] == miss_addr_q)) begin
                            if_valid_o = 1'b1;
                            if_inst_o  = inst_data_i;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            miss_addr_q <= 30'h0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_idx] <= inst_data_i;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit_evt) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign unused_sig = ^{inst_busy_i, if_addr_i[1:0]};
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
    assign unused_sig = ^{inst_busy_i, if_addr_i[1:0], hit_evt, miss_evt};
`endif

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
//   Scoreboard bench for icache_direct. Stimulus tasks drive IF and act as
//   mem_ctrl; each cycle in which the reference model says IF must receive a
//   word, the expected {pc, word} is queued. A monitor on the falling edge pops
//   and compares whenever the DUT asserts if_valid_o (or an entry is owed).
//   The model is a map from line index to the cached word address plus a
//   lazily-populated read-only instruction memory image.
// -----------------------------------------------------------------------------
module tb_icache_direct;

    localparam int IB = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jmp_wrong_i = 1'b0;
    logic        if_require_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        inst_require_o;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_data_i = 32'h0;
    logic        inst_enable_i = 1'b0;
    logic        inst_busy_i = 1'b0;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    always #5 clk = ~clk;

    icache_direct #(.INDEX_BITS(IB)) dut (
        .clk            (clk),
        .rst            (rst),
        .jmp_wrong_i    (jmp_wrong_i),
        .if_require_i   (if_require_i),
        .if_addr_i      (if_addr_i),
        .if_inst_o      (if_inst_o),
        .if_valid_o     (if_valid_o),
        .inst_require_o (inst_require_o),
        .inst_addr_o    (inst_addr_o),
        .inst_data_i    (inst_data_i),
        .inst_enable_i  (inst_enable_i),
        .inst_busy_i    (inst_busy_i),
        .hit_cnt_o      (hit_cnt_o),
        .miss_cnt_o     (miss_cnt_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    bit   [29:0] line_w  [bit [IB-1:0]];   // index -> cached word address
    logic [31:0] mem_img [bit [29:0]];     // word address -> instruction
    int unsigned hit_model  = 0;
    int unsigned miss_model = 0;

    function automatic logic [31:0] mem_word(input bit [29:0] w);
        if (!mem_img.exists(w)) mem_img[w] = $urandom;
        return mem_img[w];
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats();
`ifdef ICACHE_STATS_EN
        check32("hit_cnt", hit_cnt_o, hit_model);
        check32("miss_cnt", miss_cnt_o, miss_model);
`else
        check32("hit_cnt_tied", hit_cnt_o, 32'h0);
        check32("miss_cnt_tied", miss_cnt_o, 32'h0);
`endif
    endtask

    // Scoreboard monitor: one transaction per cycle with a valid or an owed word.
    always @(negedge clk) begin
        if (rst && (if_valid_o || exp_q.size() > 0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=1 expected=0 pc=%h", if_addr_i);
            end else begin
                mon_e = exp_q.pop_front();
                if (!if_valid_o) begin
                    failures++;
                    $display("FAIL missing_valid actual=0 expected=1 pc=%h", mon_e.addr);
                end else if (if_inst_o !== mon_e.data || if_addr_i[31:2] !== mon_e.addr[31:2]) begin
                    failures++;
                    $display("FAIL inst_data actual=%h@%h expected=%h@%h",
                             if_inst_o, if_addr_i, mon_e.data, mon_e.addr);
                end else begin
                    $display("ok  fetch pc=%h inst=%h", if_addr_i, if_inst_o);
                end
            end
        end
    end

    // Fetch one PC; on a miss, act as mem_ctrl with 'lat' wait cycles, optional
    // flush in wait cycle 'flush_at' and optional PC change during the miss.
    task automatic fetch(input logic [31:0] a, input int lat, input int flush_at, input bit chg);
        bit [29:0]   w;
        bit [IB-1:0] idx;
        bit          resp;
        bit          fl;
        w   = a[31:2];
        idx = a[IB+1:2];
        if_require_i  = 1'b1;
        if_addr_i     = a;
        jmp_wrong_i   = 1'b0;
        inst_enable_i = 1'b0;
        if (line_w.exists(idx) && line_w[idx] == w) begin
            exp_q.push_back('{a, mem_word(w)});
            hit_model++;
            #2;
            check1("hit_no_req", inst_require_o, 1'b0);
            next_cycle();
            if_require_i = 1'b0;
            return;
        end
        miss_model++;
        #2;
        check1("idle_no_req", inst_require_o, 1'b0);
        next_cycle();
        for (int c = 0; c <= lat; c++) begin
            resp = (c == lat);
            fl   = (c == flush_at);
            if (chg && c == 0) if_addr_i = a ^ 32'h0001_0000;
            jmp_wrong_i   = fl;
            inst_enable_i = resp;
            inst_data_i   = resp ? mem_word(w) : $urandom;
            if (resp && !fl && if_addr_i[31:2] == w) exp_q.push_back('{a, mem_word(w)});
            #2;
            check1("miss_req", inst_require_o, !fl && !resp);
            check32("miss_addr", inst_addr_o, {w, 2'b00});
            next_cycle();
            if (resp || fl) begin
                if (resp && !fl) line_w[idx] = w;
                break;
            end
        end
        jmp_wrong_i   = 1'b0;
        inst_enable_i = 1'b0;
        if_require_i  = 1'b0;
    endtask

    task automatic idle_flush(input logic [31:0] a);
        if_require_i = 1'b1;
        if_addr_i    = a;
        jmp_wrong_i  = 1'b1;
        #2;
        check1("flush_idle_req", inst_require_o, 1'b0);
        next_cycle();
        if_require_i = 1'b0;
        jmp_wrong_i  = 1'b0;
        #2;
        check1("flush_no_miss", inst_require_o, 1'b0);
        next_cycle();
    endtask

    task automatic idle_cycle();
        if_require_i = 1'b0;
        if_addr_i    = $urandom;
        next_cycle();
    endtask

    function automatic logic [31:0] pool_addr();
        logic [22:0] tag;
        logic [IB-1:0] idx;
        int ts;
        ts  = $urandom_range(0, 3);
        tag = (ts == 3) ? 23'h7F_FFFF : 23'(ts);
        idx = IB'($urandom_range(0, 7));
        return {tag, idx, 2'(($urandom_range(0, 3)))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [29:0] w;
        int lat;
        int fa;
        int op;
        // Reset state
        #3;
        check1("rst_valid", if_valid_o, 1'b0);
        check32("rst_inst", if_inst_o, 32'h0);
        check1("rst_req", inst_require_o, 1'b0);
        check32("rst_addr", inst_addr_o, 32'h0);
        check_stats();
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Cold miss then hit
        w = 30'h0000_1004 >> 2; mem_img[w] = 32'h00A0_0093;
        w = 30'h0000_1204 >> 2; mem_img[w] = 32'h1234_5678;
        fetch(32'h0000_1004, 5, -1, 1'b0);
        fetch(32'h0000_1004, 0, -1, 1'b0);
        check_stats();

        // Conflict eviction
        fetch(32'h0000_1204, 2, -1, 1'b0);
        fetch(32'h0000_1004, 1, -1, 1'b0);
        fetch(32'h0000_1204, 0, -1, 1'b0);
        fetch(32'h0000_1004, 1, -1, 1'b0);

        // Flush mid-miss, then the same PC must miss again
        fetch(32'h0000_2000, 3, 1, 1'b0);
        fetch(32'h0000_2000, 1, -1, 1'b0);
        // Coincident response and flush
        fetch(32'h0000_2400, 2, 2, 1'b0);
        fetch(32'h0000_2400, 1, -1, 1'b0);
        // PC changes during miss: fill but no forward, then hit
        fetch(32'h0000_2800, 2, -1, 1'b1);
        fetch(32'h0000_2800, 0, -1, 1'b0);
        idle_flush(32'h0000_2800);
        check_stats();

        // Async reset in the middle of a miss
        if_require_i = 1'b1;
        if_addr_i    = 32'h0000_3000;
        next_cycle();
        #2;
        check1("pre_rst_req", inst_require_o, 1'b1);
        rst = 1'b0;
        #1;
        check1("async_rst_req", inst_require_o, 1'b0);
        check1("async_rst_valid", if_valid_o, 1'b0);
        line_w.delete();
        hit_model  = 0;
        miss_model = 0;
        if_require_i = 1'b0;
        next_cycle();
        rst = 1'b1;
        // Late response after reset must be ignored
        inst_enable_i = 1'b1;
        inst_data_i   = $urandom;
        #2;
        check1("late_resp_req", inst_require_o, 1'b0);
        next_cycle();
        inst_enable_i = 1'b0;
        fetch(32'h0000_1004, 1, -1, 1'b0);
        fetch(32'h0000_3000, 1, -1, 1'b0);
        check_stats();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                idle_cycle();
            end else if (op == 1) begin
                idle_flush(pool_addr());
            end else begin
                lat = $urandom_range(0, 4);
                fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
                fetch(pool_addr(), lat, fa, $urandom_range(0, 6) == 0);
            end
        end
        idle_cycle();
        check_stats();
        idle_cycle();
        check32("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and mem_ctrl.
- On a hit, returns the instruction to IF in the same cycle.
- On a miss, holds inst_require/inst_addr to mem_ctrl until the byte-assembled word comes back, then fills the line and forwards the word.
- A flush from a mispredicted jump aborts an outstanding miss.

Parameters:
- INDEX_BITS, 7, number of index bits; the cache holds 2^INDEX_BITS lines.
- TAG_BITS, 30-INDEX_BITS, stored tag width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- jmp_wrong_i  in  1  flush: abort outstanding miss and drop the current fetch.
- if_require_i  in  1  IF requests an instruction this cycle.
- if_addr_i  in  32  fetch PC; bits [1:0] ignored.
- if_inst_o  out  32  instruction word.
- if_valid_o  out  1  if_inst_o is valid for if_addr_i this cycle.
- inst_require_o  out  1  fetch request to mem_ctrl.
- inst_addr_o  out  32  word-aligned fetch address to mem_ctrl.
- inst_data_i  in  32  word from mem_ctrl.
- inst_enable_i  in  1  one-cycle pulse: inst_data_i valid.
- inst_busy_i  in  1  mem_ctrl busy with a fetch; informational only, not used for control.
- hit_cnt_o  out  32  hit counter (see Optional Feature).
- miss_cnt_o  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split:
  - index = if_addr_i[INDEX_BITS+1:2]
  - tag = if_addr_i[31:INDEX_BITS+2]
- Storage:
  - data array, tag array, valid bit per line.
  - Valid bits are flops cleared by reset. Data and tag arrays are not reset.
- Reset (rst=0, async): state=IDLE, all valid bits=0, miss_addr=0, if_valid_o=0, if_inst_o=0, inst_require_o=0, inst_addr_o=0.
- State IDLE:
  - hit = if_require_i & valid[index] & (tag_array[index]==tag).
  - On hit: if_valid_o=1 and if_inst_o=data[index], combinationally in the same cycle (0-cycle hit latency).
  - On a miss with if_require_i=1 and jmp_wrong_i=0: latch miss_addr={if_addr_i[31:2],2'b00}; go to MISS next cycle. if_valid_o=0.
- State MISS:
  - inst_require_o = !inst_enable_i. The request is dropped combinationally in the response cycle so mem_ctrl does not start a second fetch.
  - inst_addr_o = miss_addr.
  - When inst_enable_i=1: write data/tag, set valid at miss_addr's index, go to IDLE.
  - Same-cycle bypass: if if_require_i=1 and if_addr_i[31:2]==miss_addr[31:2], then if_valid_o=1 and if_inst_o=inst_data_i.
  - If the fetch address changed during the miss, the line is still filled but no valid is returned.
  - Otherwise if_valid_o=0. A MISS can last any number of cycles, since mem_ctrl gives mem_require priority.
- Flush (jmp_wrong_i=1):
  - In MISS: next state IDLE, no fill, inst_require_o held 0 for that cycle. mem_ctrl self-resets on the same flush unless it is serving mem_require.
  - If inst_enable_i and jmp_wrong_i coincide, the fill is discarded.
  - In IDLE: no miss is started; hit output is suppressed (if_valid_o=0).
- Outside MISS: inst_require_o=0 and inst_addr_o=miss_addr.
- A fill overwrites any existing line at that index (conflict eviction). No write-back; instruction memory is read-only.
- Simultaneous hit lookup and fill to the same index: the old contents are read; the fill becomes visible next cycle.
- Reset asserted mid-miss: immediate return to IDLE; the response is ignored.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments once per IDLE cycle with a hit and jmp_wrong_i=0.
  - miss_cnt_o increments once per IDLE->MISS transition.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports tied to 32'h0, no counter flops.

Test Plan:
- Cold miss: reset, if_require_i=1, if_addr_i=0x00001004 → next cycle inst_require_o=1, inst_addr_o=0x00001004. After 5 cycles drive inst_enable_i=1, inst_data_i=0x00A00093 → inst_require_o=0 that cycle, if_valid_o=1, if_inst_o=0x00A00093.
- Hit: then re-request 0x00001004 → if_valid_o=1 same cycle, if_inst_o=0x00A00093, inst_require_o stays 0. With stats: hit_cnt_o=1, miss_cnt_o=1.
- Conflict: with INDEX_BITS=7, fetch 0x00001204 (same index, different tag) → miss, fill 0x12345678. Re-fetch 0x00001004 → miss again.
- Flush mid-miss: miss on 0x00002000, assert jmp_wrong_i for one cycle before inst_enable_i → IDLE next cycle, inst_require_o=0. Later fetch of 0x00002000 misses again (no stale fill).
- Coincident response and flush: inst_enable_i=1 and jmp_wrong_i=1 same cycle → if_valid_o=0, valid bit not set.
- Async reset mid-miss: drop rst during MISS between clock edges → inst_require_o=0 immediately, all lines invalid, a previously cached PC misses.
